// File: rtl/counter_a.sv
// Enabled up-counter with programmable terminal value, terminal-count strobe and sticky overflow.
// Define COUNTER_A_SATURATE_EN to hold at MAX_VAL instead of wrapping.
module counter_a #(
    parameter int unsigned           WIDTH   = 6,
    parameter logic [WIDTH-1:0]      MAX_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cnt_en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;
    logic             ovf_reg;
    logic             ovf_next;
    logic             below_max;

    // Treat any value at or above the terminal as terminal, so an out-of-range
    // count recovers on the next enabled edge.
    assign below_max = (cnt_reg < MAX_VAL);

    always_comb begin
        cnt_next = cnt_reg;
        ovf_next = ovf_reg;
        if (cnt_en) begin
            if (below_max) begin
                cnt_next = cnt_reg + 1'b1;
            end else begin
`ifdef COUNTER_A_SATURATE_EN
                cnt_next = MAX_VAL;
`else
                cnt_next = '0;
`endif
                ovf_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
        end
    end

    assign cnt = cnt_reg;
    assign ovf = ovf_reg;
    assign tc  = cnt_en && (cnt_reg == MAX_VAL);

endmodule

// File: tb/tb_counter_a.sv
// Directed self-checking bench for counter_a (default parameters, either build mode).
module tb_counter_a;

    logic       clk;
    logic       reset;
    logic       cnt_en;
    logic [5:0] cnt;
    logic       tc;
    logic       ovf;

    int total;
    int bad;

    counter_a dut (
        .clk    (clk),
        .reset  (reset),
        .cnt_en (cnt_en),
        .cnt    (cnt),
        .tc     (tc),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on falling edges (multiples of 10 ns); outputs sampled 1 ns after rising edges.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        cnt_en = 1'b0;
        #1;
        total++;
        if (cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        total++;
        if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc got=%b want=0", tc); end
        $display("reset hold: cnt=%0d ovf=%b tc=%b", cnt, ovf, tc);
        step();
        total++;
        if (cnt !== 6'd0) begin bad++; $display("FAIL reset_hold_edge got=%0d want=0", cnt); end
    endtask

    task automatic test_count_run();
        @(negedge clk);
        reset  = 1'b1;
        cnt_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            total++;
            if (cnt !== 6'(i)) begin bad++; $display("FAIL count_run got=%0d want=%0d", cnt, i); end
            total++;
            if (tc !== 1'b0) begin bad++; $display("FAIL count_run_tc got=%b want=0", tc); end
            $display("count run edge %0d: cnt=%0d", i, cnt);
        end
    endtask

    task automatic test_async_clear();
        @(negedge clk);
        reset  = 1'b0;
        cnt_en = 1'b0;
        #1;
        total++;
        if (cnt !== 6'd0) begin bad++; $display("FAIL async_clear got=%0d want=0", cnt); end
        $display("async clear at %0t: cnt=%0d", $time, cnt);
        step();
        total++;
        if (cnt !== 6'd0) begin bad++; $display("FAIL async_clear_hold got=%0d want=0", cnt); end
    endtask

    task automatic test_restart();
        @(negedge clk);
        reset  = 1'b1;
        cnt_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            total++;
            if (cnt !== 6'(i)) begin bad++; $display("FAIL restart got=%0d want=%0d", cnt, i); end
            $display("restart edge %0d: cnt=%0d", i, cnt);
        end
    endtask

    task automatic test_enable_gating();
        for (int i = 6; i <= 7; i++) begin
            step();
            total++;
            if (cnt !== 6'(i)) begin bad++; $display("FAIL gate_pre got=%0d want=%0d", cnt, i); end
        end
        @(negedge clk);
        cnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (cnt !== 6'd7) begin bad++; $display("FAIL gate_hold got=%0d want=7", cnt); end
            $display("gated edge %0d: cnt=%0d", i, cnt);
        end
        @(negedge clk);
        cnt_en = 1'b1;
        step();
        total++;
        if (cnt !== 6'd8) begin bad++; $display("FAIL gate_resume got=%0d want=8", cnt); end
        $display("gate resume: cnt=%0d", cnt);
    endtask

    task automatic test_wrap();
        logic [5:0] want_cnt;
        logic       want_tc;
        @(negedge clk);
        reset  = 1'b0;
        cnt_en = 1'b0;
        #1;
        total++;
        if (cnt !== 6'd0) begin bad++; $display("FAIL wrap_pre_reset got=%0d want=0", cnt); end
        @(negedge clk);
        reset  = 1'b1;
        cnt_en = 1'b1;
        for (int i = 1; i <= 63; i++) begin
            step();
            total++;
            if (cnt !== 6'(i)) begin bad++; $display("FAIL wrap_climb got=%0d want=%0d", cnt, i); end
        end
        total++;
        if (tc !== 1'b1) begin bad++; $display("FAIL wrap_tc_at_max got=%b want=1", tc); end
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL wrap_ovf_before got=%b want=0", ovf); end
        $display("at max: cnt=%0d tc=%b ovf=%b", cnt, tc, ovf);

`ifdef COUNTER_A_SATURATE_EN
        want_cnt = 6'd63;
        want_tc  = 1'b1;
`else
        want_cnt = 6'd0;
        want_tc  = 1'b0;
`endif
        step();
        total++;
        if (cnt !== want_cnt) begin bad++; $display("FAIL wrap_edge64 got=%0d want=%0d", cnt, want_cnt); end
        total++;
        if (ovf !== 1'b1) begin bad++; $display("FAIL wrap_ovf_set got=%b want=1", ovf); end
        total++;
        if (tc !== want_tc) begin bad++; $display("FAIL wrap_tc_after got=%b want=%b", tc, want_tc); end
        $display("edge 64: cnt=%0d ovf=%b tc=%b", cnt, ovf, tc);

        for (int i = 1; i <= 3; i++) begin
            step();
`ifdef COUNTER_A_SATURATE_EN
            want_cnt = 6'd63;
`else
            want_cnt = 6'(i);
`endif
            total++;
            if (cnt !== want_cnt) begin bad++; $display("FAIL post_wrap got=%0d want=%0d", cnt, want_cnt); end
            total++;
            if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", ovf); end
        end

        @(negedge clk);
        cnt_en = 1'b0;
        #1;
        total++;
        if (tc !== 1'b0) begin bad++; $display("FAIL tc_disabled got=%b want=0", tc); end
        step();
        total++;
        if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_hold_idle got=%b want=1", ovf); end

        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_cleared got=%b want=0", ovf); end
        total++;
        if (cnt !== 6'd0) begin bad++; $display("FAIL final_reset_cnt got=%0d want=0", cnt); end
        $display("final reset: cnt=%0d ovf=%b", cnt, ovf);
    endtask

    task automatic test_reset_overrides_enable();
        @(negedge clk);
        reset  = 1'b1;
        cnt_en = 1'b1;
        step();
        step();
        total++;
        if (cnt !== 6'd2) begin bad++; $display("FAIL override_pre got=%0d want=2", cnt); end
        @(negedge clk);
        reset = 1'b0;
        step();
        total++;
        if (cnt !== 6'd0) begin bad++; $display("FAIL override_edge got=%0d want=0", cnt); end
        $display("reset with enable high: cnt=%0d", cnt);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_count_run();
        test_async_clear();
        test_restart();
        test_enable_gating();
        test_wrap();
        test_reset_overrides_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
